// File: rtl/ocf_access_ctrl.sv
// ocf_access_ctrl: two-requester access controller for the on-chip flash
// Avalon-MM CSR and data ports. Requesters are granted round-robin. Reads
// are issued as one burst. Writes are bracketed by status polls. Each
// command ends with a done pulse that is qualified by err.
module ocf_access_ctrl #(
  parameter int ADDR_W    = 18,
  parameter int BURST_MAX = 8,
  parameter int TIMEOUT   = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_cmd_rd,
  input  logic              m0_cmd_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_burst,
  input  logic [31:0]       m0_wdata,
  output logic              m0_cmd_ack,
  output logic [31:0]       m0_rdata,
  output logic              m0_rvalid,
  output logic              m0_done,
  output logic              m0_err,
  input  logic              m1_cmd_rd,
  input  logic              m1_cmd_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_burst,
  input  logic [31:0]       m1_wdata,
  output logic              m1_cmd_ack,
  output logic [31:0]       m1_rdata,
  output logic              m1_rvalid,
  output logic              m1_done,
  output logic              m1_err,
  output logic              avmm_csr_addr,
  output logic              avmm_csr_read,
  output logic              avmm_csr_write,
  output logic [31:0]       avmm_csr_writedata,
  input  logic [31:0]       avmm_csr_readdata,
  output logic [ADDR_W-1:0] avmm_data_addr,
  output logic              avmm_data_read,
  output logic              avmm_data_write,
  output logic [31:0]       avmm_data_writedata,
  output logic [3:0]        avmm_data_burstcount,
  input  logic [31:0]       avmm_data_readdata,
  input  logic              avmm_data_readdatavalid,
  input  logic              avmm_data_waitrequest
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    BMAX     = 4'(BURST_MAX);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RD_CMD    = 3'd1;
  localparam logic [2:0] S_RD_DATA   = 3'd2;
  localparam logic [2:0] S_PRE_POLL  = 3'd3;
  localparam logic [2:0] S_WR_CMD    = 3'd4;
  localparam logic [2:0] S_POST_POLL = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;

  logic [2:0]        r_state;
  logic              r_rr;          // side preferred when both request
  logic              r_gnt;         // side owning the current command
  logic [ADDR_W-1:0] r_addr;
  logic [3:0]        r_burst;
  logic [3:0]        r_beats;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic              r_data_read;
  logic              r_data_write;
  logic              r_csr_read;
  logic [1:0]        r_phase;       // poll: 0 issue, 1 strobe out, 2 sample
  logic [TW-1:0]     r_timer;
  logic [1:0]        r_ack;
  logic [1:0]        r_done;
  logic [1:0]        r_err_o;
  logic [1:0]        r_rvalid;

  logic              w_pend0;
  logic              w_pend1;
  logic              w_sel;
  logic              w_rd;
  logic              w_wr;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_burst;
  logic [31:0]       w_wdata;
  logic              w_illegal;
  logic              w_timer_exp;
  logic              w_csr_idle;
  logic              w_unused;

  assign w_pend0     = m0_cmd_rd | m0_cmd_wr;
  assign w_pend1     = m1_cmd_rd | m1_cmd_wr;
  assign w_sel       = (w_pend0 & w_pend1) ? r_rr : w_pend1;
  assign w_rd        = w_sel ? m1_cmd_rd : m0_cmd_rd;
  assign w_wr        = w_sel ? m1_cmd_wr : m0_cmd_wr;
  assign w_addr      = w_sel ? m1_addr   : m0_addr;
  assign w_burst     = w_sel ? m1_burst  : m0_burst;
  assign w_wdata     = w_sel ? m1_wdata  : m0_wdata;
  assign w_illegal   = (w_rd & w_wr) | (w_rd & ((w_burst == 4'd0) | (w_burst > BMAX)));
  assign w_timer_exp = (r_timer == TMO_LAST);
  assign w_csr_idle  = (avmm_csr_readdata[1:0] == 2'b00);
  assign w_unused    = ^{avmm_csr_readdata[31:4], avmm_csr_readdata[2]};

  // Command sequencer: arbitration, flash access phases and completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_rr         <= 1'b0;
      r_gnt        <= 1'b0;
      r_addr       <= '0;
      r_burst      <= '0;
      r_beats      <= '0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_data_read  <= 1'b0;
      r_data_write <= 1'b0;
      r_csr_read   <= 1'b0;
      r_phase      <= '0;
      r_timer      <= '0;
      r_ack        <= '0;
      r_done       <= '0;
      r_err_o      <= '0;
      r_rvalid     <= '0;
    end else begin
      r_ack    <= '0;
      r_done   <= '0;
      r_err_o  <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_pend0 | w_pend1) begin
            r_gnt        <= w_sel;
            r_rr         <= ~w_sel;
            r_ack[w_sel] <= 1'b1;
            r_addr       <= w_addr;
            r_burst      <= w_burst;
            r_wdata      <= w_wdata;
            r_beats      <= '0;
            r_timer      <= '0;
            r_phase      <= '0;
            if (w_illegal) begin
              r_err   <= 1'b1;
              r_state <= S_FINISH;
            end else if (w_rd) begin
              r_err       <= 1'b0;
              r_data_read <= 1'b1;
              r_state     <= S_RD_CMD;
            end else begin
              r_err   <= 1'b0;
              r_state <= S_PRE_POLL;
            end
          end
        end
        S_RD_CMD: begin
          if (!avmm_data_waitrequest) begin
            r_data_read <= 1'b0;
            r_state     <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (avmm_data_readdatavalid) begin
            r_rdata         <= avmm_data_readdata;
            r_rvalid[r_gnt] <= 1'b1;
            r_timer         <= '0;
            r_beats         <= r_beats + 4'd1;
            if (r_beats + 4'd1 == r_burst) begin
              r_err   <= 1'b0;
              r_state <= S_FINISH;
            end
          end else if (w_timer_exp) begin
            r_err   <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_PRE_POLL, S_POST_POLL: begin
          if (w_timer_exp) begin
            r_csr_read <= 1'b0;
            r_err      <= 1'b1;
            r_state    <= S_FINISH;
          end else begin
            r_timer <= r_timer + TW'(1);
            case (r_phase)
              2'd0: begin
                r_csr_read <= 1'b1;
                r_phase    <= 2'd1;
              end
              2'd1: begin
                r_csr_read <= 1'b0;
                r_phase    <= 2'd2;
              end
              default: begin
                r_phase <= 2'd0;
                if (w_csr_idle) begin
                  if (r_state == S_PRE_POLL) begin
                    r_data_write <= 1'b1;
                    r_state      <= S_WR_CMD;
                  end else begin
                    r_err   <= ~avmm_csr_readdata[3];
                    r_state <= S_FINISH;
                  end
                end
              end
            endcase
          end
        end
        S_WR_CMD: begin
          if (!avmm_data_waitrequest) begin
            r_data_write <= 1'b0;
            r_timer      <= '0;
            r_phase      <= '0;
            r_state      <= S_POST_POLL;
          end
        end
        S_FINISH: begin
          r_done[r_gnt]  <= 1'b1;
          r_err_o[r_gnt] <= r_err;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_cmd_ack = r_ack[0];
  assign m0_rvalid  = r_rvalid[0];
  assign m0_rdata   = r_rvalid[0] ? r_rdata : 32'd0;
  assign m0_done    = r_done[0];
  assign m0_err     = r_err_o[0];
  assign m1_cmd_ack = r_ack[1];
  assign m1_rvalid  = r_rvalid[1];
  assign m1_rdata   = r_rvalid[1] ? r_rdata : 32'd0;
  assign m1_done    = r_done[1];
  assign m1_err     = r_err_o[1];

  // Only the status register is ever read; the CSR write path is unused.
  assign avmm_csr_addr        = 1'b0;
  assign avmm_csr_read        = r_csr_read;
  assign avmm_csr_write       = 1'b0;
  assign avmm_csr_writedata   = 32'd0;
  assign avmm_data_addr       = r_addr;
  assign avmm_data_read       = r_data_read;
  assign avmm_data_write      = r_data_write;
  assign avmm_data_writedata  = r_wdata;
  assign avmm_data_burstcount = r_data_write ? 4'd1 : (r_data_read ? r_burst : 4'd0);

endmodule

// File: tb/tb_ocf_access_ctrl.sv
// Directed testbench for ocf_access_ctrl with a small flash model.
module tb_ocf_access_ctrl;

  localparam int TIMEOUT = 4096;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [1:0]  cmd_rd, cmd_wr;
  logic [17:0] addr_r [2];
  logic [3:0]  burst_r [2];
  logic [31:0] wdata_r [2];
  logic [1:0]  ack, rvalid, done, err;
  logic [31:0] rdata [2];

  logic        avmm_csr_addr, avmm_csr_read, avmm_csr_write;
  logic [31:0] avmm_csr_writedata, avmm_csr_readdata;
  logic [17:0] avmm_data_addr;
  logic        avmm_data_read, avmm_data_write;
  logic [31:0] avmm_data_writedata, avmm_data_readdata;
  logic [3:0]  avmm_data_burstcount;
  logic        avmm_data_readdatavalid, avmm_data_waitrequest;

  ocf_access_ctrl #(.ADDR_W(18), .BURST_MAX(8), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .m0_cmd_rd(cmd_rd[0]), .m0_cmd_wr(cmd_wr[0]), .m0_addr(addr_r[0]),
    .m0_burst(burst_r[0]), .m0_wdata(wdata_r[0]), .m0_cmd_ack(ack[0]),
    .m0_rdata(rdata[0]), .m0_rvalid(rvalid[0]), .m0_done(done[0]), .m0_err(err[0]),
    .m1_cmd_rd(cmd_rd[1]), .m1_cmd_wr(cmd_wr[1]), .m1_addr(addr_r[1]),
    .m1_burst(burst_r[1]), .m1_wdata(wdata_r[1]), .m1_cmd_ack(ack[1]),
    .m1_rdata(rdata[1]), .m1_rvalid(rvalid[1]), .m1_done(done[1]), .m1_err(err[1]),
    .avmm_csr_addr(avmm_csr_addr), .avmm_csr_read(avmm_csr_read),
    .avmm_csr_write(avmm_csr_write), .avmm_csr_writedata(avmm_csr_writedata),
    .avmm_csr_readdata(avmm_csr_readdata),
    .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read),
    .avmm_data_write(avmm_data_write), .avmm_data_writedata(avmm_data_writedata),
    .avmm_data_burstcount(avmm_data_burstcount), .avmm_data_readdata(avmm_data_readdata),
    .avmm_data_readdatavalid(avmm_data_readdatavalid),
    .avmm_data_waitrequest(avmm_data_waitrequest)
  );

  // ---------------- flash model ----------------
  int          stall_n = 1;
  bit          gap_en = 1'b0;
  logic [31:0] status_pre = 32'h18;
  logic [31:0] status_post = 32'h18;

  int          stall_cnt, rd_left;
  logic [17:0] rd_ptr;
  bit          gap_tog, wrote;
  int          wr_acc_n = 0, csr_rd_n = 0, csr_at_wr = 0;
  logic [31:0] mem [logic [17:0]];

  function automatic logic [31:0] peek(input logic [17:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0], a[15:0]};
  endfunction

  assign avmm_data_waitrequest = (avmm_data_read | avmm_data_write) && (stall_cnt < stall_n);

  // Model: stalls each command stall_n cycles, streams beats, answers status reads with latency 1.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt <= 0; rd_left <= 0; gap_tog <= 1'b0; wrote <= 1'b0;
      avmm_data_readdatavalid <= 1'b0; avmm_data_readdata <= '0; avmm_csr_readdata <= '0;
    end else begin
      if ((avmm_data_read | avmm_data_write) && avmm_data_waitrequest) stall_cnt <= stall_cnt + 1;
      else stall_cnt <= 0;
      avmm_data_readdatavalid <= 1'b0;
      if (avmm_data_read && !avmm_data_waitrequest) begin
        rd_ptr <= avmm_data_addr; rd_left <= int'(avmm_data_burstcount); gap_tog <= 1'b0;
      end else if (rd_left > 0) begin
        if (gap_en && !gap_tog) gap_tog <= 1'b1;
        else begin
          avmm_data_readdatavalid <= 1'b1;
          avmm_data_readdata <= peek(rd_ptr);
          rd_ptr <= rd_ptr + 18'd1; rd_left <= rd_left - 1; gap_tog <= 1'b0;
        end
      end
      if (avmm_data_write && !avmm_data_waitrequest) begin
        mem[avmm_data_addr] = avmm_data_writedata;
        wr_acc_n <= wr_acc_n + 1; csr_at_wr <= csr_rd_n; wrote <= 1'b1;
      end
      if (avmm_csr_read) begin
        avmm_csr_readdata <= wrote ? status_post : status_pre;
        csr_rd_n <= csr_rd_n + 1;
      end
      if (|done) wrote <= 1'b0;
    end
  end

  // ---------------- monitor ----------------
  int          ack_n [2] = '{0, 0};
  int          done_n [2] = '{0, 0};
  int          rd_cyc = 0;
  logic [31:0] rv_q0 [$];
  logic [31:0] rv_q1 [$];
  int          order_q [$];

  // Monitor: log acks, beats, done order and data-read strobe cycles.
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (ack[k]) ack_n[k]++;
      if (done[k]) begin done_n[k]++; order_q.push_back(k); end
    end
    if (rvalid[0]) rv_q0.push_back(rdata[0]);
    if (rvalid[1]) rv_q1.push_back(rdata[1]);
    if (avmm_data_read) rd_cyc++;
  end

  function automatic bit outs_nz();
    return |{ack, rvalid, done, err, rdata[0], rdata[1], avmm_csr_addr, avmm_csr_read,
             avmm_csr_write, avmm_csr_writedata, avmm_data_addr, avmm_data_read,
             avmm_data_write, avmm_data_writedata, avmm_data_burstcount};
  endfunction

  int n_assert = 0;
  int n_fail = 0;

  // Issue one command on side s, hold until ack, then wait for done; lat counts cycles ack->done.
  task automatic run_cmd(input int s, input logic rd, input logic wr, input logic [17:0] a,
                         input logic [3:0] b, input logic [31:0] wd, input int lim,
                         output bit ok, output int lat, output logic e);
    bit acked;
    acked = 1'b0; ok = 1'b0; lat = 0; e = 1'b0;
    @(negedge clock);
    cmd_rd[s] = rd; cmd_wr[s] = wr; addr_r[s] = a; burst_r[s] = b; wdata_r[s] = wd;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ack[s]) begin acked = 1'b1; break; end
    end
    cmd_rd[s] = 1'b0; cmd_wr[s] = 1'b0;
    if (acked) begin
      for (int j = 1; j <= lim; j++) begin
        @(negedge clock);
        if (done[s]) begin ok = 1'b1; lat = j; e = err[s]; break; end
      end
    end
    @(negedge clock); #1;
  endtask

  // Both sides raise a read on the same cycle; returns once both finished or the bound expires.
  task automatic drive_pair(output bit ok);
    bit got0, got1;
    got0 = 1'b0; got1 = 1'b0; ok = 1'b0;
    @(negedge clock);
    addr_r[0] = 18'h00020; addr_r[1] = 18'h00040; burst_r[0] = 4'd2; burst_r[1] = 4'd2;
    cmd_wr = 2'b00; cmd_rd = 2'b11;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (ack[0]) cmd_rd[0] = 1'b0;
      if (ack[1]) cmd_rd[1] = 1'b0;
      if (done[0]) got0 = 1'b1;
      if (done[1]) got1 = 1'b1;
      if (got0 && got1) begin ok = 1'b1; break; end
    end
    cmd_rd = 2'b00;
    @(negedge clock); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_assert++;
    if (outs_nz() !== 1'b0) begin n_fail++; $display("FAIL reset_outputs: nonzero=%b, expected 0", outs_nz()); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_read();
    bit ok; int lat; logic e; int s_ack0, s_m1, s_rv0;
    logic [31:0] exp_d [4];
    exp_d = '{32'h00100010, 32'h00110011, 32'h00120012, 32'h00130013};
    stall_n = 2; gap_en = 1'b1;
    s_ack0 = ack_n[0]; s_rv0 = rv_q0.size(); s_m1 = ack_n[1] + done_n[1] + rv_q1.size();
    run_cmd(0, 1'b1, 1'b0, 18'h00010, 4'd4, 32'd0, 200, ok, lat, e);
    n_assert++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL read_done: got %b, expected 1", ok); end
    n_assert++;
    if (e !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b, expected 0", e); end
    n_assert++;
    if (ack_n[0] - s_ack0 !== 1) begin n_fail++; $display("FAIL read_ack_count: got %0d, expected 1", ack_n[0] - s_ack0); end
    n_assert++;
    if (rv_q0.size() - s_rv0 !== 4) begin n_fail++; $display("FAIL read_beat_count: got %0d, expected 4", rv_q0.size() - s_rv0); end
    else begin
      for (int k = 0; k < 4; k++) begin
        n_assert++;
        if (rv_q0[s_rv0 + k] !== exp_d[k]) begin
          n_fail++; $display("FAIL read_beat%0d: got %h, expected %h", k, rv_q0[s_rv0 + k], exp_d[k]);
        end
      end
    end
    n_assert++;
    if (ack_n[1] + done_n[1] + rv_q1.size() - s_m1 !== 0) begin
      n_fail++; $display("FAIL read_m1_quiet: got %0d events, expected 0", ack_n[1] + done_n[1] + rv_q1.size() - s_m1);
    end
    $display("read m0 addr 00010 burst 4: done=%b err=%b", ok, e);
  endtask

  task automatic test_write();
    bit ok; int lat; logic e; int s_wr, s_csr, s_rv0;
    stall_n = 1; gap_en = 1'b0; status_pre = 32'h18; status_post = 32'h18;
    s_wr = wr_acc_n; s_csr = csr_rd_n;
    run_cmd(0, 1'b0, 1'b1, 18'h00100, 4'd0, 32'hDEADBEEF, 500, ok, lat, e);
    n_assert++;
    if ({ok, e} !== 2'b10) begin n_fail++; $display("FAIL write_done_err: got done=%b err=%b, expected done=1 err=0", ok, e); end
    n_assert++;
    if (wr_acc_n - s_wr !== 1) begin n_fail++; $display("FAIL write_count: got %0d, expected 1", wr_acc_n - s_wr); end
    n_assert++;
    if ((csr_at_wr > s_csr) !== 1'b1) begin n_fail++; $display("FAIL write_prepoll: got %0d csr reads before write, expected >=1", csr_at_wr - s_csr); end
    s_rv0 = rv_q0.size();
    run_cmd(0, 1'b1, 1'b0, 18'h00100, 4'd1, 32'd0, 200, ok, lat, e);
    n_assert++;
    if (rv_q0.size() - s_rv0 !== 1) begin n_fail++; $display("FAIL readback_count: got %0d, expected 1", rv_q0.size() - s_rv0); end
    else begin
      n_assert++;
      if (rv_q0[s_rv0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL readback_data: got %h, expected deadbeef", rv_q0[s_rv0]); end
    end
    $display("write m0 addr 00100 data deadbeef then readback: err=%b", e);
  endtask

  task automatic test_arbitration();
    bit ok; int lat; logic e; int s_ord, s_rv0, s_rv1;
    @(negedge clock); reset = 1'b1; @(negedge clock); reset = 1'b0;
    stall_n = 0; gap_en = 1'b0;
    s_ord = order_q.size(); s_rv0 = rv_q0.size(); s_rv1 = rv_q1.size();
    drive_pair(ok);
    n_assert++;
    if ((ok && order_q.size() - s_ord == 2) !== 1'b1) begin n_fail++; $display("FAIL arb1_complete: got ok=%b dones=%0d, expected 2", ok, order_q.size() - s_ord); end
    else begin
      n_assert++;
      if ({order_q[s_ord], order_q[s_ord + 1]} !== {32'd0, 32'd1}) begin
        n_fail++; $display("FAIL arb1_order: got %0d,%0d, expected 0,1", order_q[s_ord], order_q[s_ord + 1]);
      end
      n_assert++;
      if ({rv_q0[s_rv0], rv_q1[s_rv1 + 1]} !== {32'h00200020, 32'h00410041}) begin
        n_fail++; $display("FAIL arb1_data: got %h %h, expected 00200020 00410041", rv_q0[s_rv0], rv_q1[s_rv1 + 1]);
      end
    end
    // A single m0 command hands the pointer to m1 for the next tie.
    run_cmd(0, 1'b1, 1'b0, 18'h00030, 4'd1, 32'd0, 200, ok, lat, e);
    s_ord = order_q.size();
    drive_pair(ok);
    n_assert++;
    if ((ok && order_q.size() - s_ord == 2) !== 1'b1) begin n_fail++; $display("FAIL arb2_complete: got ok=%b dones=%0d, expected 2", ok, order_q.size() - s_ord); end
    else begin
      n_assert++;
      if ({order_q[s_ord], order_q[s_ord + 1]} !== {32'd1, 32'd0}) begin
        n_fail++; $display("FAIL arb2_order: got %0d,%0d, expected 1,0", order_q[s_ord], order_q[s_ord + 1]);
      end
    end
    $display("arbitration: two simultaneous read pairs served");
  endtask

  task automatic test_illegal();
    bit ok; int lat; logic e; int s_rd;
    logic [3:0] bursts [2];
    bursts = '{4'd0, 4'd9};
    s_rd = rd_cyc;
    for (int k = 0; k < 2; k++) begin
      run_cmd(1, 1'b1, 1'b0, 18'h00050, bursts[k], 32'd0, 20, ok, lat, e);
      n_assert++;
      if ({ok, e} !== 2'b11) begin n_fail++; $display("FAIL illegal_b%0d_err: got done=%b err=%b, expected 1 1", bursts[k], ok, e); end
      n_assert++;
      if ((lat >= 1 && lat <= 2) !== 1'b1) begin n_fail++; $display("FAIL illegal_b%0d_latency: got %0d, expected 1..2", bursts[k], lat); end
      $display("illegal m1 read burst %0d: err=%b latency=%0d", bursts[k], e, lat);
    end
    run_cmd(1, 1'b1, 1'b1, 18'h00050, 4'd1, 32'd0, 20, ok, lat, e);
    n_assert++;
    if ({ok, e} !== 2'b11) begin n_fail++; $display("FAIL illegal_rdwr_err: got done=%b err=%b, expected 1 1", ok, e); end
    n_assert++;
    if (rd_cyc - s_rd !== 0) begin n_fail++; $display("FAIL illegal_no_read: got %0d read cycles, expected 0", rd_cyc - s_rd); end
  endtask

  task automatic test_timeout();
    bit ok; int lat; logic e; int s_wr;
    status_pre = 32'h02; status_post = 32'h02; s_wr = wr_acc_n;
    run_cmd(0, 1'b0, 1'b1, 18'h00120, 4'd0, 32'h12345678, TIMEOUT + 100, ok, lat, e);
    n_assert++;
    if ({ok, e} !== 2'b11) begin n_fail++; $display("FAIL prepoll_timeout_err: got done=%b err=%b, expected 1 1", ok, e); end
    n_assert++;
    if (lat !== TIMEOUT + 1) begin n_fail++; $display("FAIL prepoll_timeout_latency: got %0d, expected %0d", lat, TIMEOUT + 1); end
    n_assert++;
    if (wr_acc_n - s_wr !== 0) begin n_fail++; $display("FAIL prepoll_timeout_nowrite: got %0d, expected 0", wr_acc_n - s_wr); end
    $display("write with busy status: err=%b latency=%0d", e, lat);
    status_pre = 32'h00; status_post = 32'h10; s_wr = wr_acc_n;
    run_cmd(0, 1'b0, 1'b1, 18'h00140, 4'd0, 32'h0BADF00D, 500, ok, lat, e);
    n_assert++;
    if ({ok, e} !== 2'b11) begin n_fail++; $display("FAIL postpoll_ws0_err: got done=%b err=%b, expected 1 1", ok, e); end
    n_assert++;
    if (wr_acc_n - s_wr !== 1) begin n_fail++; $display("FAIL postpoll_ws0_write: got %0d, expected 1", wr_acc_n - s_wr); end
    $display("write with post-poll status 10: err=%b", e);
    status_pre = 32'h18; status_post = 32'h18;
  endtask

  task automatic test_reset_mid();
    bit ok, acked; int lat; logic e; int s_done0, s_rv0;
    stall_n = 0; gap_en = 1'b1; acked = 1'b0;
    s_done0 = done_n[0]; s_rv0 = rv_q0.size();
    @(negedge clock);
    addr_r[0] = 18'h00080; burst_r[0] = 4'd8; cmd_rd[0] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (ack[0]) begin acked = 1'b1; break; end
    end
    cmd_rd[0] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #1;
      if (rv_q0.size() - s_rv0 >= 3) break;
    end
    n_assert++;
    if ((acked && rv_q0.size() - s_rv0 >= 3) !== 1'b1) begin n_fail++; $display("FAIL midreset_setup: got %0d beats, expected >=3", rv_q0.size() - s_rv0); end
    reset = 1'b1; #1;
    n_assert++;
    if (outs_nz() !== 1'b0) begin n_fail++; $display("FAIL midreset_outputs: nonzero=%b, expected 0", outs_nz()); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock); #1;
    n_assert++;
    if (done_n[0] - s_done0 !== 0) begin n_fail++; $display("FAIL midreset_nodone: got %0d, expected 0", done_n[0] - s_done0); end
    s_rv0 = rv_q0.size();
    run_cmd(0, 1'b1, 1'b0, 18'h00200, 4'd2, 32'd0, 200, ok, lat, e);
    n_assert++;
    if ({ok, e} !== 2'b10) begin n_fail++; $display("FAIL postreset_read: got done=%b err=%b, expected 1 0", ok, e); end
    n_assert++;
    if (rv_q0.size() - s_rv0 !== 2) begin n_fail++; $display("FAIL postreset_beats: got %0d, expected 2", rv_q0.size() - s_rv0); end
    else begin
      n_assert++;
      if ({rv_q0[s_rv0], rv_q0[s_rv0 + 1]} !== {32'h02000200, 32'h02010201}) begin
        n_fail++; $display("FAIL postreset_data: got %h %h, expected 02000200 02010201", rv_q0[s_rv0], rv_q0[s_rv0 + 1]);
      end
    end
    $display("reset during burst-8 read, then read 00200 burst 2: err=%b", e);
  endtask

  initial begin
    cmd_rd = 2'b00; cmd_wr = 2'b00;
    for (int k = 0; k < 2; k++) begin addr_r[k] = '0; burst_r[k] = '0; wdata_r[k] = '0; end
    test_reset();
    test_read();
    test_write();
    test_arbitration();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
